// File: rtl/patch_streamer.sv
// Serializes the patchifier's parallel patch array into a valid/ready pixel stream,
// patch-major then position order, and releases the patchifier after the final beat.
module patch_streamer #(
  parameter int PIXEL_WIDTH       = 24,
  parameter int IMG_WIDTH         = 64,
  parameter int IMG_HEIGHT        = 64,
  parameter int PATCH_SIZE        = 16,
  parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE),
  parameter int PATCH_VECTOR_SIZE = PATCH_SIZE*PATCH_SIZE,
  parameter int PIDX_W            = $clog2(TOTAL_NUM_PATCHES),
  parameter int POS_W             = $clog2(PATCH_VECTOR_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              in_state,
  input  logic [TOTAL_NUM_PATCHES-1:0][PATCH_VECTOR_SIZE-1:0][PIXEL_WIDTH-1:0] all_patches,
  output logic                    output_taken,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PIXEL_WIDTH-1:0]  out_data,
  output logic [PIDX_W-1:0]       out_patch_idx,
  output logic [POS_W-1:0]        out_pos_idx,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    out_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err
);

  localparam logic [1:0]        IN_DONE  = 2'b10;
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(PATCH_VECTOR_SIZE-1);
  localparam logic [PIDX_W-1:0] PIDX_MAX = PIDX_W'(TOTAL_NUM_PATCHES-1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RELEASE} state_t;

  state_t                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic                     taken_q, taken_d;
  logic                     err_q, err_d;
  logic [PIDX_W-1:0]        patch_q, patch_d;
  logic [POS_W-1:0]         pos_q, pos_d;
  logic [PIXEL_WIDTH-1:0]   data_q, data_d;
  logic                     eop, last, fire;

  assign eop  = (pos_q == POS_MAX);
  assign last = eop && (patch_q == PIDX_MAX);
  assign fire = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    taken_d = 1'b0;
    err_d   = err_q;
    patch_d = patch_q;
    pos_d   = pos_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (start && in_state == IN_DONE) begin
          state_d = S_STREAM;
          valid_d = 1'b1;
          patch_d = '0;
          pos_d   = '0;
          data_d  = all_patches[0][0];
        end
      end
      S_STREAM: begin
        // Source array no longer guaranteed stable: abort without releasing.
        if (in_state != IN_DONE) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = S_IDLE;
          patch_d = '0;
          pos_d   = '0;
          data_d  = '0;
        end else if (fire) begin
          if (last) begin
            valid_d = 1'b0;
            taken_d = 1'b1;
            state_d = S_RELEASE;
            patch_d = '0;
            pos_d   = '0;
            data_d  = '0;
          end else begin
            pos_d   = eop ? '0 : pos_q + 1'b1;
            patch_d = eop ? patch_q + 1'b1 : patch_q;
            data_d  = all_patches[patch_d][pos_d];
          end
        end
      end
      S_RELEASE: begin
        if (in_state != IN_DONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      patch_q <= '0;
      pos_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      patch_q <= patch_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
    end
  end

  assign output_taken  = taken_q;
  assign frame_done    = taken_q;
  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_patch_idx = patch_q;
  assign out_pos_idx   = pos_q;
  assign out_sop       = (pos_q == '0);
  assign out_eop       = eop;
  assign out_last      = last;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;

endmodule
